// File: rtl/lfsr_word_ctrl_if.sv
// Word hand-off port between the LFSR word sequencer and its consumer.
// The sequencer is the master; the consumer drives word_ready.
interface lfsr_word_ctrl_if #(
  parameter int WORD_W = 16
) ();

  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready;

  modport master (
    output word_out,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_out,
    input  word_valid,
    output word_ready
  );

endinterface

// File: rtl/lfsr_word_ctrl.sv
// Seeds an external 8-bit shift-right LFSR, samples its serial output every cycle
// and packs WORD_W bits per word into a one-word valid/ready output buffer.
module lfsr_word_ctrl #(
  parameter int         WORD_W       = 16,
  parameter logic [7:0] DEFAULT_SEED = 8'hA5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             stop,
  input  logic [7:0]       seed_in,
  input  logic [7:0]       num_words,
  output logic             lfsr_rst,
  output logic [7:0]       lfsr_seed,
  input  logic             lfsr_dout,
  lfsr_word_ctrl_if.master wbus,
  output logic             busy,
  output logic             done,
  output logic [7:0]       overrun_cnt
);

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COLLECT = 2'd2
  } state_t;

  state_t            state;
  logic [BIT_W-1:0]  bit_cnt;
  logic [7:0]        word_cnt;
  logic [7:0]        num_lat;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] next_word;
  logic              word_complete;
  logic              last_word;
  logic              take;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_word          = shreg;
    next_word[bit_cnt] = lfsr_dout;
  end

  // start/stop take priority over collection, so a word never completes on their edge.
  assign word_complete = (state == COLLECT) && !stop && !start && (bit_cnt == LAST_BIT);
  assign last_word     = (num_lat != 8'd0) && ((word_cnt + 8'd1) == num_lat);
  assign take          = wbus.word_valid && wbus.word_ready;

  assign lfsr_rst = RST || (state == LOAD);
  assign busy     = (state != IDLE);

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      word_cnt      <= 8'd0;
      num_lat       <= 8'd0;
      shreg         <= '0;
      lfsr_seed     <= DEFAULT_SEED;
      wbus.word_out <= '0;
      wbus.word_valid <= 1'b0;
      done          <= 1'b0;
      overrun_cnt   <= 8'd0;
    end else begin
      done <= 1'b0;

      // Output buffer: reload when empty or emptying this edge, otherwise drop and count.
      if (word_complete && (!wbus.word_valid || take)) begin
        wbus.word_out   <= next_word;
        wbus.word_valid <= 1'b1;
      end else if (take) begin
        wbus.word_valid <= 1'b0;
      end

      if (word_complete && wbus.word_valid && !take && (overrun_cnt != 8'hFF)) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end

      if (stop) begin
        state <= IDLE;
      end else if (start) begin
        lfsr_seed   <= (seed_in == 8'h00) ? DEFAULT_SEED : seed_in;
        num_lat     <= num_words;
        bit_cnt     <= '0;
        word_cnt    <= 8'd0;
        overrun_cnt <= 8'd0;
        state       <= LOAD;
      end else begin
        case (state)
          LOAD: begin
            state <= COLLECT;
          end
          COLLECT: begin
            shreg <= next_word;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt  <= '0;
              word_cnt <= word_cnt + 8'd1;
              if (last_word) begin
                done  <= 1'b1;
                state <= IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_word_ctrl.sv
// Directed and randomized checks of lfsr_word_ctrl against a bit-stream reference
// derived from the LFSR recurrence b[n] = b[n-6] ^ b[n-4].
module tb_lfsr_word_ctrl;

  localparam int W = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] seed_in = 8'h00;
  logic [7:0] num_words = 8'h00;
  logic       lfsr_rst;
  logic [7:0] lfsr_seed;
  logic       lfsr_dout;
  logic       busy;
  logic       done;
  logic [7:0] overrun_cnt;
  logic [7:0] sr;

  int checks = 0;
  int errors = 0;

  logic [7:0]   s, s2, n;
  bit           ok;
  int           k;
  logic [W-1:0] w;

  lfsr_word_ctrl_if #(.WORD_W(W)) wbus ();

  lfsr_word_ctrl #(.WORD_W(W), .DEFAULT_SEED(8'hA5)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .stop        (stop),
    .seed_in     (seed_in),
    .num_words   (num_words),
    .lfsr_rst    (lfsr_rst),
    .lfsr_seed   (lfsr_seed),
    .lfsr_dout   (lfsr_dout),
    .wbus        (wbus),
    .busy        (busy),
    .done        (done),
    .overrun_cnt (overrun_cnt)
  );

  always #5 CLK = ~CLK;

  // The LFSR the sequencer drives: load on reset, else shift right with SR[2]^SR[4] in at the top.
  always @(posedge CLK) begin
    if (lfsr_rst) sr <= lfsr_seed;
    else          sr <= {sr[2] ^ sr[4], sr[7:1]};
  end
  assign lfsr_dout = sr[0];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] eff(input logic [7:0] seed);
    return (seed == 8'h00) ? 8'hA5 : seed;
  endfunction

  // Word idx (0-based) of the serial stream starting from seed.
  function automatic logic [31:0] ref_word(input logic [7:0] seed, input int idx);
    bit bits [0:511];
    logic [31:0] r;
    for (int i = 0; i < 512; i++) begin
      if (i < 8) bits[i] = seed[i];
      else       bits[i] = bits[i-6] ^ bits[i-4];
    end
    r = 32'd0;
    for (int j = 0; j < W; j++) r[j] = bits[idx*W + j];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(input int max, output bit got);
    got = 1'b0;
    for (int c = 0; c < max && !got; c++) begin
      tick();
      if (done) got = 1'b1;
    end
  endtask

  task automatic take_word();
    wbus.word_ready = 1'b1;
    tick();
    wbus.word_ready = 1'b0;
  endtask

  initial begin
    wbus.word_ready = 1'b0;

    // Reset values
    tick(); tick();
    check("rst_valid", 32'(wbus.word_valid), 32'd0);
    check("rst_word", 32'(wbus.word_out), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overrun", 32'(overrun_cnt), 32'd0);
    check("rst_seed", 32'(lfsr_seed), 32'hA5);
    check("rst_lfsr_rst", 32'(lfsr_rst), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    RST = 1'b0;
    tick();
    check("idle_lfsr_rst", 32'(lfsr_rst), 32'd0);

    // Seed 0x14, one word, exact latency
    seed_in = 8'h14; num_words = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("load_busy", 32'(busy), 32'd1);
    check("load_lfsr_rst", 32'(lfsr_rst), 32'd1);
    check("load_seed", 32'(lfsr_seed), 32'h14);
    repeat (W) tick();
    check("lat_not_yet", 32'(wbus.word_valid), 32'd0);
    tick();
    check("lat_valid", 32'(wbus.word_valid), 32'd1);
    check("seed14_word", 32'(wbus.word_out), 32'h4414);
    check("seed14_ref", 32'(wbus.word_out), ref_word(8'h14, 0));
    check("seed14_done", 32'(done), 32'd1);
    check("seed14_busy", 32'(busy), 32'd0);
    tick();
    check("done_pulse", 32'(done), 32'd0);
    check("hold_valid", 32'(wbus.word_valid), 32'd1);
    take_word();
    check("taken", 32'(wbus.word_valid), 32'd0);

    // Zero seed selects the default
    seed_in = 8'h00; num_words = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_seed", 32'(lfsr_seed), 32'hA5);
    wait_done(W + 4, ok);
    check("zero_done", 32'(ok), 32'd1);
    w = wbus.word_out;
    check("zero_low", 32'(w[7:0]), 32'hA5);
    check("zero_word", 32'(w), ref_word(8'hA5, 0));
    take_word();

    // Randomized runs with the consumer always ready
    for (int r = 0; r < 4; r++) begin
      s = 8'($urandom_range(1, 255));
      n = 8'($urandom_range(1, 4));
      seed_in = s; num_words = n; wbus.word_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      k = 0; ok = 1'b0;
      for (int c = 0; c < (32'(n) + 1) * W + 8 && !ok; c++) begin
        tick();
        if (wbus.word_valid) begin
          check("rnd_word", 32'(wbus.word_out), ref_word(s, k));
          k++;
        end
        if (done) ok = 1'b1;
      end
      check("rnd_done", 32'(ok), 32'd1);
      check("rnd_count", 32'(k), 32'(n));
      check("rnd_overrun", 32'(overrun_cnt), 32'd0);
      tick();
      check("rnd_drained", 32'(wbus.word_valid), 32'd0);
      wbus.word_ready = 1'b0;
    end

    // Backpressure: three words, consumer never ready
    s = 8'($urandom_range(1, 255));
    seed_in = s; num_words = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2 * W) tick();
    check("bp_stable_mid", 32'(wbus.word_out), ref_word(s, 0));
    wait_done(2 * W, ok);
    check("bp_done", 32'(ok), 32'd1);
    check("bp_overrun", 32'(overrun_cnt), 32'd2);
    check("bp_valid", 32'(wbus.word_valid), 32'd1);
    check("bp_word", 32'(wbus.word_out), ref_word(s, 0));
    take_word();

    // Handover: ready on the edge word 2 completes
    s = 8'($urandom_range(1, 255));
    seed_in = s; num_words = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2 * W) tick();
    check("ho_word1", 32'(wbus.word_out), ref_word(s, 0));
    wbus.word_ready = 1'b1;
    tick();
    check("ho_valid", 32'(wbus.word_valid), 32'd1);
    check("ho_word2", 32'(wbus.word_out), ref_word(s, 1));
    check("ho_overrun", 32'(overrun_cnt), 32'd0);
    check("ho_done", 32'(done), 32'd1);
    tick();
    check("ho_drained", 32'(wbus.word_valid), 32'd0);
    wbus.word_ready = 1'b0;

    // Stop mid word 2 in free-run
    s = 8'($urandom_range(1, 255));
    seed_in = s; num_words = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (W + 1 + W / 2) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_done", 32'(done), 32'd0);
    check("stop_valid", 32'(wbus.word_valid), 32'd1);
    repeat (2 * W) tick();
    check("stop_word", 32'(wbus.word_out), ref_word(s, 0));
    check("stop_overrun", 32'(overrun_cnt), 32'd0);
    take_word();

    // Restart while busy uses the new seed
    s = 8'($urandom_range(1, 255));
    s2 = 8'($urandom_range(1, 255));
    seed_in = s; num_words = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    seed_in = s2; start = 1'b1;
    tick();
    start = 1'b0;
    check("rs_seed", 32'(lfsr_seed), 32'(s2));
    wait_done(W + 4, ok);
    check("rs_done", 32'(ok), 32'd1);
    check("rs_word", 32'(wbus.word_out), ref_word(s2, 0));
    take_word();

    // Overrun counter saturation
    s = 8'($urandom_range(1, 255));
    seed_in = s; num_words = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (260 * W) tick();
    check("sat_overrun", 32'(overrun_cnt), 32'd255);
    check("sat_busy", 32'(busy), 32'd1);
    check("sat_word", 32'(wbus.word_out), ref_word(s, 0));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    take_word();

    // Reset mid-collection, then start & stop together
    s = 8'($urandom_range(1, 255));
    seed_in = s; num_words = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (W + 5) tick();
    check("mid_valid", 32'(wbus.word_valid), 32'd1);
    RST = 1'b1;
    tick();
    check("mrst_valid", 32'(wbus.word_valid), 32'd0);
    check("mrst_word", 32'(wbus.word_out), 32'd0);
    check("mrst_overrun", 32'(overrun_cnt), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_seed", 32'(lfsr_seed), 32'hA5);
    check("mrst_lfsr_rst", 32'(lfsr_rst), 32'd1);
    RST = 1'b0;
    seed_in = 8'h3C; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("ss_busy", 32'(busy), 32'd0);
    check("ss_lfsr_rst", 32'(lfsr_rst), 32'd0);
    check("ss_seed", 32'(lfsr_seed), 32'hA5);
    tick();
    check("ss_still_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
